// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: ramps a PWM duty value up to full scale, holds it, ramps it back to zero, holds it, and repeats, stepping on PWM period ticks.
module pwm_duty_ramp #(
  parameter int PWM_RESOLUTION = 8,
  parameter int TICKS_PER_STEP = 1,
  parameter int HOLD_TICKS     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PWM_RESOLUTION-1:0] step,
  input  logic                      period_tick,
  output logic [PWM_RESOLUTION-1:0] duty_cycle,
  output logic                      duty_valid,
  output logic [2:0]                phase,
  output logic                      cycle_done
);
  localparam int W  = PWM_RESOLUTION;
  localparam int CW = $clog2((TICKS_PER_STEP > HOLD_TICKS ? TICKS_PER_STEP : HOLD_TICKS) + 1);
  localparam logic [W-1:0] DMAX = '1;
  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0] step_reg, step_nxt, duty_nxt, up_val, dn_val;
  logic [W:0] sum;
  logic hit_step, hit_hold, upd, valid_nxt, done_nxt;
  assign phase = state;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      step_reg   <= '0;
      duty_cycle <= '0;
      duty_valid <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      step_reg   <= step_nxt;
      duty_cycle <= duty_nxt;
      duty_valid <= valid_nxt;
      cycle_done <= done_nxt;
    end
  end
  // Sum is one bit wider so the saturating add never wraps.
  always_comb begin
    hit_step = period_tick && cnt == CW'(TICKS_PER_STEP - 1);
    hit_hold = period_tick && cnt == CW'(HOLD_TICKS - 1);
    sum      = {1'b0, duty_cycle} + {1'b0, step_reg};
    up_val   = sum[W] ? DMAX : sum[W-1:0];
    dn_val   = duty_cycle > step_reg ? duty_cycle - step_reg : '0;
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else
      case (state)
        IDLE:      state_nxt = RAMP_UP;
        RAMP_UP:   state_nxt = (hit_step && up_val == DMAX) ? HOLD_HIGH : RAMP_UP;
        HOLD_HIGH: state_nxt = hit_hold ? RAMP_DOWN : HOLD_HIGH;
        RAMP_DOWN: state_nxt = (hit_step && dn_val == '0) ? HOLD_LOW : RAMP_DOWN;
        HOLD_LOW:  state_nxt = hit_hold ? RAMP_UP : HOLD_LOW;
        default:   state_nxt = IDLE;
      endcase
  end
  always_comb begin
    upd       = en && (state == RAMP_UP || state == RAMP_DOWN) && hit_step;
    duty_nxt  = !en ? '0 : upd ? (state == RAMP_UP ? up_val : dn_val) : duty_cycle;
    valid_nxt = upd;
    done_nxt  = en && state == HOLD_LOW && hit_hold;
    cnt_nxt   = (state_nxt != state || !en) ? '0 : period_tick ? (((state == RAMP_UP || state == RAMP_DOWN) ? hit_step : hit_hold) ? '0 : cnt + 1'b1) : cnt;
    step_nxt  = (state_nxt == RAMP_UP && state != RAMP_UP) ? (step == '0 ? W'(1) : step) : step_reg;
  end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed checks of the duty ramp sequencer with default parameters.
module tb_pwm_duty_ramp;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, period_tick = 1'b0;
  logic [7:0] step = 8'd64;
  logic [7:0] duty_cycle;
  logic duty_valid, cycle_done;
  logic [2:0] phase;
  int n_run = 0, n_fail = 0, vcnt = 0, dcnt = 0;
  pwm_duty_ramp #(.PWM_RESOLUTION(8), .TICKS_PER_STEP(1), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .period_tick(period_tick),
    .duty_cycle(duty_cycle), .duty_valid(duty_valid), .phase(phase), .cycle_done(cycle_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (duty_valid === 1'b1) vcnt++;
    if (cycle_done === 1'b1) dcnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input int gap);
    repeat (gap - 1) clk_step();
    period_tick = 1'b1;
    clk_step();
    period_tick = 1'b0;
  endtask
  task automatic full_cycle(input int gap, input logic change);
    int up[4] = '{64, 128, 192, 255};
    int dn[4] = '{191, 127, 63, 0};
    for (int i = 0; i < 4; i++) begin
      tick(gap);
      if (i == 0 && change) step = 8'd16;
      chk("up_duty", duty_cycle, up[i]);
      chk("up_phase", phase, i == 3 ? 2 : 1);
      chk("up_valid", duty_valid, 1);
    end
    clk_step();
    chk("valid_one_clk", duty_valid, 0);
    tick(gap);
    chk("hh_phase", phase, 2);
    chk("hh_duty", duty_cycle, 255);
    tick(gap);
    chk("hh_exit", phase, 3);
    chk("hh_valid", duty_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(gap);
      chk("dn_duty", duty_cycle, dn[i]);
      chk("dn_phase", phase, i == 3 ? 4 : 3);
      chk("dn_valid", duty_valid, 1);
    end
    tick(gap);
    chk("hl_phase", phase, 4);
    chk("hl_done", cycle_done, 0);
    tick(gap);
    chk("hl_exit", phase, 1);
    chk("cycle_done", cycle_done, 1);
    chk("hl_duty", duty_cycle, 0);
    clk_step();
    chk("done_one_clk", cycle_done, 0);
  endtask
  initial begin
    int v0, d0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      period_tick = i[0];
      clk_step();
      chk("rst_duty", duty_cycle, 0);
      chk("rst_phase", phase, 0);
    end
    period_tick = 1'b0;
    chk("rst_valid_pulses", vcnt, 0);
    chk("rst_done_pulses", dcnt, 0);
    rst = 1'b1;
    clk_step();
    chk("start_phase", phase, 1);
    chk("start_duty", duty_cycle, 0);
    chk("start_valid", duty_valid, 0);
    v0 = vcnt; d0 = dcnt;
    full_cycle(256, 1'b0);
    chk("cycle_valid_pulses", vcnt - v0, 8);
    chk("cycle_done_pulses", dcnt - d0, 1);
    full_cycle(3, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick(3);
      chk("step16_duty", duty_cycle, 16 * i);
    end
    en = 1'b0;
    period_tick = 1'b1;
    clk_step();
    period_tick = 1'b0;
    chk("en_drop_duty", duty_cycle, 0);
    chk("en_drop_phase", phase, 0);
    chk("en_drop_valid", duty_valid, 0);
    en = 1'b1;
    step = 8'd0;
    clk_step();
    chk("step0_enter", phase, 1);
    for (int i = 1; i <= 255; i++) begin
      tick(1);
      chk("step0_duty", duty_cycle, i);
      chk("step0_phase", phase, i == 255 ? 2 : 1);
    end
    rst = 1'b0;
    clk_step();
    chk("hh_rst_duty", duty_cycle, 0);
    chk("hh_rst_phase", phase, 0);
    chk("hh_rst_valid", duty_valid, 0);
    chk("hh_rst_done", cycle_done, 0);
    rst = 1'b1;
    step = 8'd64;
    clk_step();
    chk("restart_phase", phase, 1);
    chk("restart_duty0", duty_cycle, 0);
    tick(1);
    chk("restart_duty", duty_cycle, 64);
    en = 1'b0;
    clk_step();
    v0 = vcnt;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("idle_phase", phase, 0);
      chk("idle_duty", duty_cycle, 0);
    end
    chk("idle_valid_pulses", vcnt - v0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ramp.md
PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 SHALL have parameter PWM_RESOLUTION, default 8: width of duty_cycle; full scale is DMAX = 2^PWM_RESOLUTION - 1.
REQ-002 SHALL have parameter TICKS_PER_STEP, default 1, legal range >= 1: number of period_tick strobes between successive duty updates while ramping.
REQ-003 SHALL have parameter HOLD_TICKS, default 2, legal range >= 1: number of period_tick strobes spent in each hold state.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-006 SHALL have port en, input, 1 bit: 1 = run the ramp sequence; 0 = return to idle.
REQ-007 SHALL have port step, input, PWM_RESOLUTION bits: duty increment/decrement per update; value 0 is treated as 1.
REQ-008 SHALL have port period_tick, input, 1 bit: one-clock strobe issued by the downstream PWM generator at each PWM period wrap.
REQ-009 SHALL have port duty_cycle, output, PWM_RESOLUTION bits, registered: duty value fed to the PWM generator.
REQ-010 SHALL have port duty_valid, output, 1 bit, registered: one-clock pulse in the same cycle duty_cycle takes a new value.
REQ-011 SHALL have port phase, output, 3 bits, registered: current state, encoded IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
REQ-012 SHALL have port cycle_done, output, 1 bit, registered: one-clock pulse when a full up/hold/down/hold cycle completes.

Function
REQ-013 SHALL implement the FSM IDLE -> RAMP_UP -> HOLD_HIGH -> RAMP_DOWN -> HOLD_LOW -> RAMP_UP, repeating while en=1.
REQ-014 SHALL leave IDLE for RAMP_UP on the first clock with en=1; duty_cycle stays 0 on that transition and duty_valid stays 0.
REQ-015 SHALL latch step, with 0 replaced by 1, into an internal step register on every entry to RAMP_UP; step changes at any other time SHALL have no effect.
REQ-016 SHALL keep a tick counter that clears on every state entry and advances only on clocks with period_tick=1.
REQ-017 In ramp states, SHALL perform an update on the period_tick where the tick counter equals TICKS_PER_STEP-1, then clear the counter.
REQ-018 RAMP_UP update SHALL set duty_cycle = min(duty_cycle + step_reg, DMAX), computed one bit wider so no wrap occurs; on reaching DMAX the FSM SHALL enter HOLD_HIGH in the same clock.
REQ-019 RAMP_DOWN update SHALL set duty_cycle = max(duty_cycle - step_reg, 0) with no underflow; on reaching 0 the FSM SHALL enter HOLD_LOW in the same clock.
REQ-020 Hold states SHALL keep duty_cycle constant and exit on the period_tick where the tick counter equals HOLD_TICKS-1.
REQ-021 HOLD_LOW exit SHALL enter RAMP_UP and pulse cycle_done for exactly one clock.
REQ-022 Latency SHALL be one clock: a qualifying period_tick at edge k causes duty_cycle, duty_valid and phase to change at edge k+1.
REQ-023 en=0 in any non-IDLE state SHALL, at the next edge, force phase=IDLE, duty_cycle=0, duty_valid=0 and cycle_done=0, and clear the counters; en=0 takes priority over a simultaneous period_tick.
REQ-024 period_tick while en=0 or while in IDLE SHALL be ignored.
REQ-025 Clocks without period_tick SHALL hold all state; duty_valid and cycle_done SHALL never be asserted for more than one consecutive clock.

Reset
REQ-026 When rst=0 at an edge, the block SHALL set phase=IDLE, duty_cycle=0, duty_valid=0 and cycle_done=0, and clear the tick counter and step register; reset SHALL take priority over en and period_tick.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence with no further pulses; after release the block SHALL restart from IDLE.

Verification (PWM_RESOLUTION=8, TICKS_PER_STEP=1, HOLD_TICKS=2)
REQ-028 Reset check: hold rst=0 for 5 clocks with en=1 and period_tick toggling -> duty_cycle=0, phase=0, no duty_valid or cycle_done pulses.
REQ-029 Full cycle with step=64 and a tick every 256 clocks -> duty_cycle 64, 128, 192, 255 (phase becomes 2 with the 255 update), hold 2 ticks, then 191, 127, 63, 0 (phase becomes 4), hold 2 ticks, then cycle_done pulses once with phase=1.
REQ-030 step=0 -> duty_cycle increments by 1 per tick and reaches 255 after 255 ticks.
REQ-031 en dropped on the same clock as a qualifying tick while duty_cycle=128 -> next clock duty_cycle=0, phase=0, duty_valid=0.
REQ-032 step changed from 64 to 16 in mid RAMP_UP -> the remaining up/down updates still use 64; the next RAMP_UP uses 16.
REQ-033 rst=0 during HOLD_HIGH -> next clock all outputs are 0; after release with en=1 the ramp restarts from 0.
